// File: rtl/sm_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM
// states and the per-operation context latched at launch.
package sm_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam logic [1:0] MD_IDLE  = 2'd0;
  localparam logic [1:0] MD_CALC  = 2'd1;
  localparam logic [1:0] MD_FIXUP = 2'd2;

  typedef enum logic { STEP_MUL = 1'b0, STEP_DIV = 1'b1 } stepMode_t;

  typedef struct packed {
    logic isDiv;
    logic negRes;   // product / quotient must be negated
    logic negRem;   // remainder takes the (negative) dividend sign
    logic divZero;
  } mdCtx_t;

endpackage

// File: rtl/sm_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Purely combinational; the parent registers acc/sreg each clock.
module sm_muldiv_step
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] sreg,
  input  logic [WIDTH:0]   operand,
  input  stepMode_t        mode,
  output logic [WIDTH:0]   accNext,
  output logic [WIDTH-1:0] sregNext
);

  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   shifted;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, operand};
    shifted  = {acc[WIDTH-1:0], sreg[WIDTH-1]};
    diff     = {1'b0, shifted} - {1'b0, operand};
    accNext  = acc;
    sregNext = sreg;
    if (mode == STEP_MUL) begin
      // {acc,sreg} shifts right; the multiplier bit leaves sreg[0]
      if (sreg[0]) begin
        accNext  = sum[WIDTH+1:1];
        sregNext = {sum[0], sreg[WIDTH-1:1]};
      end else begin
        accNext  = {1'b0, acc[WIDTH:1]};
        sregNext = {acc[0], sreg[WIDTH-1:1]};
      end
    end else begin
      // quotient bits enter sreg from the right as dividend bits leave the left
      if (!diff[WIDTH+1]) begin
        accNext  = diff[WIDTH:0];
        sregNext = {sreg[WIDTH-2:0], 1'b1};
      end else begin
        accNext  = shifted;
        sregNext = {sreg[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative signed/unsigned MULT/DIV unit producing a HI/LO pair, one result
// bit per clock. Operates on magnitudes and fixes signs in a final cycle.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  mdCtx_t           ctx;
  logic [WIDTH:0]   acc, operand, accNext;
  logic [WIDTH-1:0] sreg, sregNext;

  logic             isSigned, aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, hiFix, loFix;

  assign busy = (state != MD_IDLE);

  sm_muldiv_step #(.WIDTH(WIDTH)) uStep (
    .acc      (acc),
    .sreg     (sreg),
    .operand  (operand),
    .mode     (ctx.isDiv ? STEP_DIV : STEP_MUL),
    .accNext  (accNext),
    .sregNext (sregNext)
  );

  always_comb begin
    isSigned = ~op[0];
    aNeg     = isSigned & srcA[WIDTH-1];
    bNeg     = isSigned & srcB[WIDTH-1];
    aMag     = aNeg ? (~srcA + 1'b1) : srcA;
    bMag     = bNeg ? (~srcB + 1'b1) : srcB;
  end

  // sign fixup; a zero divisor yields all-ones quotient, remainder == srcA
  always_comb begin
    prod = {acc[WIDTH-1:0], sreg};
    if (ctx.negRes) prod = -prod;
    quo  = ctx.negRes ? -sreg : sreg;
    rem  = ctx.negRem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    if (ctx.isDiv) begin
      hiFix = rem;
      loFix = ctx.divZero ? '1 : quo;
    end else begin
      hiFix = prod[2*WIDTH-1:WIDTH];
      loFix = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      ctx     <= '0;
      acc     <= '0;
      sreg    <= '0;
      operand <= '0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      divZero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start && !kill) begin
            ctx.isDiv   <= op[1];
            ctx.negRes  <= aNeg ^ bNeg;
            ctx.negRem  <= op[1] & aNeg;
            ctx.divZero <= op[1] & (srcB == '0);
            acc         <= '0;
            sreg        <= aMag;
            operand     <= {1'b0, bMag};
            cnt         <= CNT_W'(WIDTH - 1);
            divZero     <= 1'b0;
            state       <= MD_CALC;
          end
        end
        MD_CALC: begin
          if (kill) begin
            state <= MD_IDLE;
          end else begin
            acc  <= accNext;
            sreg <= sregNext;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) state <= MD_FIXUP;
          end
        end
        MD_FIXUP: begin
          state <= MD_IDLE;
          if (!kill) begin
            hi      <= hiFix;
            lo      <= loFix;
            divZero <= ctx.divZero;
            done    <= 1'b1;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_muldiv.sv
// Scoreboard bench for sm_muldiv at WIDTH=32 (directed + random) and WIDTH=8 (random).
module tb_sm_muldiv;
  import sm_muldiv_pkg::*;

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, kill, busy, done, divZero;
  logic [1:0]  op;
  logic [31:0] srcA, srcB, hi, lo;

  logic        start8, kill8, busy8, done8, divZero8;
  logic [1:0]  op8;
  logic [7:0]  srcA8, srcB8, hi8, lo8;

  int   nChecks = 0;
  int   nFails  = 0;
  exp_t q32[$];
  exp_t q8[$];

  sm_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .kill(kill), .busy(busy), .done(done), .hi(hi), .lo(lo), .divZero(divZero)
  );

  sm_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .srcA(srcA8), .srcB(srcB8),
    .kill(kill8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .divZero(divZero8)
  );

  // Independent arithmetic reference using 64-bit host math
  function automatic exp_t refModel(input int w, input logic [1:0] opc,
                                    input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a    = a & mask;
    b    = b & mask;
    sa   = longint'(a);
    sb   = longint'(b);
    if (!opc[0]) begin
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
    end
    e.dz = 1'b0;
    if (!opc[1]) begin
      p    = sa * sb;
      e.lo = p[31:0] & mask;
      e.hi = 32'(p >> w) & mask;
    end else if (b == 32'd0) begin
      e.lo = mask;
      e.hi = a;
      e.dz = 1'b1;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      e.lo = 32'(q) & mask;
      e.hi = 32'(r) & mask;
    end
    return e;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return mask;
      3:       return 32'd1 << (w - 1);
      default: return $urandom & mask;
    endcase
  endfunction

  // Caller is at a negedge; returns one negedge after the start edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit track, input exp_t e);
    start = 1'b1; op = o; srcA = a; srcB = b;
    if (track) q32.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue8(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start8 = 1'b1; op8 = o; srcA8 = a[7:0]; srcB8 = b[7:0];
    q8.push_back(refModel(8, o, a, b));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic waitDone8(output int lat);
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; kill = 0; op = 0; srcA = 0; srcB = 0;
    start8 = 0; kill8 = 0; op8 = 0; srcA8 = 0; srcB8 = 0;
    repeat (3) @(negedge clk);
    nChecks++;
    if ({busy, done, divZero, hi, lo} !== 67'd0) begin
      nFails++;
      $display("FAIL reset32: got busy=%b done=%b dz=%b hi=%h lo=%h, want all zero", busy, done, divZero, hi, lo);
    end
    nChecks++;
    if ({busy8, done8, divZero8, hi8, lo8} !== 19'd0) begin
      nFails++;
      $display("FAIL reset8: got busy=%b done=%b dz=%b hi=%h lo=%h, want all zero", busy8, done8, divZero8, hi8, lo8);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu_max();
    int   lat;
    exp_t e, g;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, '{1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    nChecks++;
    if (busy !== 1'b1) begin nFails++; $display("FAIL multu_busy: got %b, want 1", busy); end
    waitDone(lat);
    nChecks++;
    if (lat !== 33 || busy !== 1'b0) begin
      nFails++; $display("FAIL multu_latency: got lat=%0d busy=%b, want lat=33 busy=0", lat, busy);
    end
    if (done === 1'b1 && q32.size() > 0) begin
      e = q32.pop_front(); g = '{divZero, hi, lo};
      nChecks++;
      if (g !== e) begin nFails++; $display("FAIL multu_result: got %h, want %h", g, e); end
    end
    @(negedge clk);
    nChecks++;
    if (done !== 1'b0) begin nFails++; $display("FAIL multu_done_pulse: got done=%b, want 0", done); end
  endtask

  // Signed/unsigned directed table including divide-by-zero and overflow
  task automatic test_directed();
    logic [1:0]  tOp[7];
    logic [31:0] tA[7], tB[7];
    exp_t        tE[7];
    exp_t        g;
    int          lat;
    tOp[0] = MD_MULT; tA[0] = 32'hFFFF_FFF9; tB[0] = 32'd3;         tE[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tOp[1] = MD_DIV;  tA[1] = 32'hFFFF_FFF9; tB[1] = 32'd2;         tE[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tOp[2] = MD_DIV;  tA[2] = 32'd7;         tB[2] = 32'hFFFF_FFFE; tE[2] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFD};
    tOp[3] = MD_MULT; tA[3] = 32'h8000_0000; tB[3] = 32'h8000_0000; tE[3] = '{1'b0, 32'h4000_0000, 32'h0000_0000};
    tOp[4] = MD_DIVU; tA[4] = 32'd100;       tB[4] = 32'd0;         tE[4] = '{1'b1, 32'd100, 32'hFFFF_FFFF};
    tOp[5] = MD_DIV;  tA[5] = 32'h8000_0000; tB[5] = 32'hFFFF_FFFF; tE[5] = '{1'b0, 32'h0000_0000, 32'h8000_0000};
    tOp[6] = MD_DIV;  tA[6] = 32'hFFFF_FFFB; tB[6] = 32'd0;         tE[6] = '{1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      issue(tOp[i], tA[i], tB[i], 1, tE[i]);
      waitDone(lat);
      if (q32.size() > 0) begin
        g = '{divZero, hi, lo};
        nChecks++;
        if (lat !== 33 || g !== q32[0]) begin
          nFails++; $display("FAIL directed_%0d: got lat=%0d res=%h, want lat=33 res=%h", i, lat, g, q32[0]);
        end
        void'(q32.pop_front());
      end
    end
    // divZero must clear as soon as the next start is accepted
    issue(MD_DIVU, 32'd100, 32'd7, 1, '{1'b0, 32'd2, 32'd14});
    nChecks++;
    if (divZero !== 1'b0) begin nFails++; $display("FAIL divzero_clear: got %b, want 0", divZero); end
    waitDone(lat);
    if (q32.size() > 0) begin
      g = '{divZero, hi, lo};
      nChecks++;
      if (g !== q32[0]) begin nFails++; $display("FAIL divu_after_zero: got %h, want %h", g, q32[0]); end
      void'(q32.pop_front());
    end
  endtask

  task automatic test_busy_ignore();
    int   lat;
    bit   extra;
    exp_t g;
    issue(MD_DIVU, 32'd1000, 32'd3, 1, '{1'b0, 32'd1, 32'd333});
    repeat (4) @(negedge clk);
    start = 1'b1; op = MD_MULTU; srcA = 32'd5; srcB = 32'd5;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat);
    if (q32.size() > 0) begin
      g = '{divZero, hi, lo};
      nChecks++;
      if (lat !== 28 || g !== q32[0]) begin
        nFails++; $display("FAIL busy_ignore: got lat=%0d res=%h, want lat=28 res=%h", lat, g, q32[0]);
      end
      void'(q32.pop_front());
    end
    extra = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) extra = 1; end
    nChecks++;
    if (extra) begin nFails++; $display("FAIL busy_ignore_queued: got extra done, want none"); end
  endtask

  task automatic test_kill();
    logic [31:0] hiPrev, loPrev;
    logic        dzPrev;
    bit          sawDone;
    hiPrev = hi; loPrev = lo; dzPrev = divZero;
    issue(MD_DIVU, 32'h1234_5678, 32'd9, 0, '0);
    repeat (9) @(negedge clk);
    nChecks++;
    if (busy !== 1'b1) begin nFails++; $display("FAIL kill_pre_busy: got %b, want 1", busy); end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    nChecks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nFails++; $display("FAIL kill_abort: got busy=%b done=%b, want 0 0", busy, done);
    end
    // start together with kill while idle launches nothing
    start = 1'b1; kill = 1'b1; op = MD_MULT; srcA = 32'd3; srcB = 32'd4;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    nChecks++;
    if (busy !== 1'b0) begin nFails++; $display("FAIL kill_idle_start: got busy=%b, want 0", busy); end
    sawDone = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) sawDone = 1; end
    nChecks++;
    if (sawDone || hi !== hiPrev || lo !== loPrev || divZero !== dzPrev) begin
      nFails++;
      $display("FAIL kill_hold: got done=%b hi=%h lo=%h dz=%b, want done=0 hi=%h lo=%h dz=%b",
               sawDone, hi, lo, divZero, hiPrev, loPrev, dzPrev);
    end
  endtask

  task automatic test_rst_mid();
    bit sawDone;
    issue(MD_MULT, 32'd3, 32'd5, 0, '0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nChecks++;
    if ({busy, done, divZero, hi, lo} !== 67'd0) begin
      nFails++;
      $display("FAIL rst_mid: got busy=%b done=%b dz=%b hi=%h lo=%h, want all zero", busy, done, divZero, hi, lo);
    end
    sawDone = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) sawDone = 1; end
    nChecks++;
    if (sawDone) begin nFails++; $display("FAIL rst_mid_done: got done pulse, want none"); end
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t g;
    issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1, '{1'b0, 32'h1, 32'h0});
    waitDone(lat);
    if (q32.size() > 0) begin
      g = '{divZero, hi, lo};
      nChecks++;
      if (g !== q32[0]) begin nFails++; $display("FAIL b2b_first: got %h, want %h", g, q32[0]); end
      void'(q32.pop_front());
    end
    issue(MD_DIVU, 32'hFFFF_FFFF, 32'd10, 1, '{1'b0, 32'd5, 32'h1999_9999});
    waitDone(lat);
    if (q32.size() > 0) begin
      g = '{divZero, hi, lo};
      nChecks++;
      if (lat !== 33 || g !== q32[0]) begin
        nFails++; $display("FAIL b2b_second: got lat=%0d res=%h, want lat=33 res=%h", lat, g, q32[0]);
      end
      void'(q32.pop_front());
    end
  endtask

  task automatic test_random32();
    int          lat;
    logic [1:0]  o;
    logic [31:0] a, b;
    exp_t        g;
    for (int i = 0; i < 400; i++) begin
      o = 2'(i % 4); a = pick(32); b = pick(32);
      issue(o, a, b, 1, refModel(32, o, a, b));
      waitDone(lat);
      if (q32.size() > 0) begin
        g = '{divZero, hi, lo};
        nChecks++;
        if (lat !== 33 || g !== q32[0]) begin
          nFails++;
          $display("FAIL rand32 op=%0d a=%h b=%h: got lat=%0d res=%h, want lat=33 res=%h", o, a, b, lat, g, q32[0]);
        end
        void'(q32.pop_front());
      end
    end
  endtask

  task automatic test_random8();
    int          lat;
    logic [1:0]  o;
    logic [31:0] a, b;
    exp_t        g;
    for (int i = 0; i < 1000; i++) begin
      o = 2'(i % 4); a = pick(8); b = pick(8);
      issue8(o, a, b);
      waitDone8(lat);
      if (q8.size() > 0) begin
        g = '{divZero8, {24'd0, hi8}, {24'd0, lo8}};
        nChecks++;
        if (lat !== 9 || g !== q8[0]) begin
          nFails++;
          $display("FAIL rand8 op=%0d a=%h b=%h: got lat=%0d res=%h, want lat=9 res=%h", o, a[7:0], b[7:0], lat, g, q8[0]);
        end
        void'(q8.pop_front());
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_directed();
    test_busy_ignore();
    test_kill();
    test_rst_mid();
    test_back_to_back();
    test_random32();
    test_random8();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
